// File: rtl/req_encoder_8_3_pkg.sv
// Shared widths, state encoding and default priority direction for the
// registered request encoder and its helper blocks.
package enc_pkg;

   localparam int REQ_W  = 8;
   localparam int CODE_W = 3;

   // 1 = index 7 wins, 0 = index 0 wins
   localparam bit HIGH_FIRST_DEF = 1'b1;

   // The state is exactly the V flag: IDLE means nothing is presented
   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PRESENT = 1'b1
   } state_t;

endpackage

// File: rtl/req_encoder_8_3_if.sv
// Request/ack bundle between the request sources, the encoder and the
// consumer. The master side drives requests, mask and ack; the slave side
// (the encoder) returns the presented code, valid flag and pending bits.
interface req_encoder_8_3_if;
   import enc_pkg::*;

   logic [REQ_W-1:0]  D;    // request lines
   logic [REQ_W-1:0]  M;    // capture mask
   logic              ack;  // consumer accepts Y
   logic [CODE_W-1:0] Y;    // presented code
   logic              V;    // Y is valid
   logic [REQ_W-1:0]  P;    // pending-request register

   modport master (
      output D, M, ack,
      input  Y, V, P
   );

   modport slave (
      input  D, M, ack,
      output Y, V, P
   );

endinterface

// File: rtl/req_encoder_8_3_dec.sv
// Combinational 3-to-8 one-hot decoder, used to find the bit that an
// acknowledged code retires.
module decoder_3_8
   import enc_pkg::*;
(
   input  logic [CODE_W-1:0] i_code,
   output logic [REQ_W-1:0]  o_onehot
);

   // Raise exactly the bit selected by the code
   always_comb begin
      o_onehot         = '0;
      o_onehot[i_code] = 1'b1;
   end

endmodule

// File: rtl/req_encoder_8_3_prio.sv
// Combinational 8-to-3 priority encoder. o_any flags a non-zero input;
// o_code is 0 when nothing is set.
module priority_encoder_8_3
   import enc_pkg::*;
#(
   parameter bit HIGH_FIRST = HIGH_FIRST_DEF
)
(
   input  logic [REQ_W-1:0]  i_req,
   output logic [CODE_W-1:0] o_code,
   output logic              o_any
);

   // Scan in ascending priority order so the last hit is the winner
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      o_code = '0;
      o_any  = |i_req;
      if (HIGH_FIRST) begin
         for (int i = 0; i < REQ_W; i++) begin
            if (i_req[i]) o_code = CODE_W'(i);
         end
      end else begin
         for (int i = REQ_W - 1; i >= 0; i--) begin
            if (i_req[i]) o_code = CODE_W'(i);
         end
      end
   end

endmodule

// File: rtl/req_encoder_8_3.sv
// Registered 8-to-3 request encoder. Requests are captured into a sticky
// pending register; the highest-priority pending one is presented on Y with
// V and held until acked, at which point only that bit is retired and the
// next pending request (if any) is presented on the following cycle.
module req_encoder_8_3
   import enc_pkg::*;
#(
   parameter bit HIGH_FIRST = HIGH_FIRST_DEF
)
(
   input logic              clk,
   input logic              rst,
   req_encoder_8_3_if.slave if_req
);

   state_t              r_state;
   logic [CODE_W-1:0]   r_code;
   logic [REQ_W-1:0]    r_pend;

   state_t              w_state_nxt;
   logic [CODE_W-1:0]   w_code_nxt;
   logic [REQ_W-1:0]    w_pend_nxt;

   logic [REQ_W-1:0]    w_capture;
   logic [REQ_W-1:0]    w_req;
   logic [REQ_W-1:0]    w_retire;
   logic [REQ_W-1:0]    w_after_ack;
   logic [CODE_W-1:0]   w_req_code;
   logic                w_req_any;
   logic [CODE_W-1:0]   w_ack_code;
   logic                w_ack_any;

   // New requests allowed through the mask; the mask never clears pending bits
   assign w_capture   = if_req.D & if_req.M;
   assign w_req       = r_pend | w_capture;
   // Retire the presented bit, but a same-cycle re-assertion sets it again
   assign w_after_ack = (r_pend & ~w_retire) | w_capture;

   priority_encoder_8_3 #(.HIGH_FIRST(HIGH_FIRST)) u_enc_req (
      .i_req  (w_req),
      .o_code (w_req_code),
      .o_any  (w_req_any)
   );

   priority_encoder_8_3 #(.HIGH_FIRST(HIGH_FIRST)) u_enc_ack (
      .i_req  (w_after_ack),
      .o_code (w_ack_code),
      .o_any  (w_ack_any)
   );

   decoder_3_8 u_dec (
      .i_code   (r_code),
      .o_onehot (w_retire)
   );

   // Next-state logic: load on first request, hold while presenting, advance on ack
   always_comb begin
      w_state_nxt = r_state;
      w_code_nxt  = r_code;
      w_pend_nxt  = w_req;
      unique case (r_state)
         ST_IDLE: begin
            // ack has no effect here
            if (w_req_any) begin
               w_code_nxt  = w_req_code;
               w_state_nxt = ST_PRESENT;
            end else begin
               w_code_nxt  = '0;
            end
         end
         ST_PRESENT: begin
            // Without ack the code is held even if a higher request arrives
            if (if_req.ack) begin
               if (w_ack_any) begin
                  w_pend_nxt = w_after_ack;
                  w_code_nxt = w_ack_code;
               end else begin
                  w_pend_nxt  = '0;
                  w_code_nxt  = '0;
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         default: begin
            w_pend_nxt  = '0;
            w_code_nxt  = '0;
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State, code and pending registers; reset discards everything in flight
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (rst) begin
         r_state <= ST_IDLE;
         r_code  <= '0;
         r_pend  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_code  <= w_code_nxt;
         r_pend  <= w_pend_nxt;
      end
   end

   assign if_req.Y = r_code;
   assign if_req.V = (r_state == ST_PRESENT);
   assign if_req.P = r_pend;

endmodule

// File: tb/tb_req_encoder_8_3.sv
// Directed bench for req_encoder_8_3. Two instances: one high-index-first,
// one low-index-first. Each step drives inputs, queues the expected state
// after the next edge, then pops and compares it 1 ns after that edge.
module tb_req_encoder_8_3;
   import enc_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;

   req_encoder_8_3_if if_hi ();
   req_encoder_8_3_if if_lo ();

   req_encoder_8_3 #(.HIGH_FIRST(1'b1)) dut_hi (
      .clk    (clk),
      .rst    (rst),
      .if_req (if_hi.slave)
   );

   req_encoder_8_3 #(.HIGH_FIRST(1'b0)) dut_lo (
      .clk    (clk),
      .rst    (rst),
      .if_req (if_lo.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      tag;
      bit         lo;
      logic       v;
      logic [2:0] y;
      logic [7:0] p;
   } exp_t;

   exp_t sb[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of stimulus on the selected instance (the other idles),
   // queue the expectation, then compare after the edge.
   task automatic step(input string tag, input bit lo, input logic [7:0] d,
                       input logic [7:0] m, input logic ack, input logic rs,
                       input logic v, input logic [2:0] y, input logic [7:0] p);
      exp_t e;
      exp_t got;
      rst = rs;
      if (lo) begin
         if_lo.D = d; if_lo.M = m; if_lo.ack = ack;
         if_hi.D = 8'h00; if_hi.M = 8'hFF; if_hi.ack = 1'b0;
      end else begin
         if_hi.D = d; if_hi.M = m; if_hi.ack = ack;
         if_lo.D = 8'h00; if_lo.M = 8'hFF; if_lo.ack = 1'b0;
      end
      e.tag = tag; e.lo = lo; e.v = v; e.y = y; e.p = p;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, 8'h01, 8'h00);
      end else begin
         got = sb.pop_front();
         if (got.lo) begin
            check({got.tag, "_V"}, {7'd0, if_lo.V}, {7'd0, got.v});
            check({got.tag, "_Y"}, {5'd0, if_lo.Y}, {5'd0, got.y});
            check({got.tag, "_P"}, if_lo.P, got.p);
         end else begin
            check({got.tag, "_V"}, {7'd0, if_hi.V}, {7'd0, got.v});
            check({got.tag, "_Y"}, {5'd0, if_hi.Y}, {5'd0, got.y});
            check({got.tag, "_P"}, if_hi.P, got.p);
         end
      end
   endtask

   initial begin
      if_hi.D = 8'hFF; if_hi.M = 8'hFF; if_hi.ack = 1'b0;
      if_lo.D = 8'h00; if_lo.M = 8'hFF; if_lo.ack = 1'b0;
      #1;

      // Reset overrides active requests; release presents the top request
      step("rst_a",    0, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00);
      step("rst_b",    0, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00);
      step("rst_rel",  0, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1, 3'd7, 8'hFF);
      step("rst_clr",  0, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00);

      // Single request held until ack, then retired
      step("single",   0, 8'h10, 8'hFF, 1'b0, 1'b0, 1'b1, 3'd4, 8'h10);
      for (int i = 0; i < 5; i++)
         step("hold",  0, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1, 3'd4, 8'h10);
      step("s_ack",    0, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
      step("s_idle",   0, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
      step("ack_idle", 0, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00);

      // Back-to-back, high index first: 7,5,2,0
      step("b2b_h7",   0, 8'hA5, 8'hFF, 1'b1, 1'b0, 1'b1, 3'd7, 8'hA5);
      step("b2b_h5",   0, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b1, 3'd5, 8'h25);
      step("b2b_h2",   0, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b1, 3'd2, 8'h05);
      step("b2b_h0",   0, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b1, 3'd0, 8'h01);
      step("b2b_hend", 0, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00);

      // Back-to-back, low index first: 0,2,5,7
      step("b2b_l0",   1, 8'hA5, 8'hFF, 1'b1, 1'b0, 1'b1, 3'd0, 8'hA5);
      step("b2b_l2",   1, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b1, 3'd2, 8'hA4);
      step("b2b_l5",   1, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b1, 3'd5, 8'hA0);
      step("b2b_l7",   1, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b1, 3'd7, 8'h80);
      step("b2b_lend", 1, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00);

      // No preemption, then set beats clear on the acked bit
      step("np_3",     0, 8'h08, 8'hFF, 1'b0, 1'b0, 1'b1, 3'd3, 8'h08);
      step("np_hold",  0, 8'h80, 8'hFF, 1'b0, 1'b0, 1'b1, 3'd3, 8'h88);
      step("sw_7",     0, 8'h08, 8'hFF, 1'b1, 1'b0, 1'b1, 3'd7, 8'h88);
      step("sw_3",     0, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b1, 3'd3, 8'h08);
      step("sw_end",   0, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00);

      // Mask gates capture only
      step("mask_blk", 0, 8'hF0, 8'h0F, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
      step("mask_on",  0, 8'hF0, 8'hFF, 1'b0, 1'b0, 1'b1, 3'd7, 8'hF0);
      step("mask_off", 0, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 3'd7, 8'hF0);

      // Reset mid-handshake wins over ack and live requests
      step("mid_clr",  0, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00);
      step("mid_3c",   0, 8'h3C, 8'hFF, 1'b0, 1'b0, 1'b1, 3'd5, 8'h3C);
      step("mid_rst",  0, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00);
      step("post_a",   0, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
      step("post_b",   0, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/req_encoder_8_3.md
# req_encoder_8_3

Registered 8-to-3 request encoder with pending-request capture and a valid/ack handshake: the sequential counterpart to the 3-to-8 decoder. Eight request lines are latched into a pending register. The highest-priority pending request is presented as a 3-bit code with a valid flag and held stable until acknowledged, at which point that request is retired. It sits between request sources (interrupt-style lines, arbiter requests) and a consumer that selects one of eight targets by code, typically through the 3-to-8 decoder.

## Interface
- HIGH_FIRST, default 1: 1 = index 7 has highest priority; 0 = index 0 has highest priority.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- D  input  8  request lines, level-sensitive, sampled every clk edge.
- M  input  8  capture mask; bit i = 1 allows D[i] to set pending bit i.
- ack  input  1  consumer accepts the presented code; meaningful only while V = 1.
- Y  output  3  encoded index of the presented request; 0 whenever V = 0.
- V  output  1  Y holds a valid pending request.
- P  output  8  pending-request register, for visibility.

## Operation
- req = P | (D & M), combinational. M gates capture only; already-pending bits survive M deasserting.
- enc(x) = index of the highest-priority set bit of x per HIGH_FIRST. enc(0) is unused.
- State is the V bit:
  - IDLE (V = 0): if req ≠ 0, load P ← req, Y ← enc(req), V ← 1 (→ PRESENT). Otherwise P ← 0, Y ← 0, stay in IDLE.
  - PRESENT (V = 1), ack = 0: P ← req, Y and V held. A newly arriving higher-priority request does not preempt the presented code.
  - PRESENT, ack = 1: nxt = (P & ~onehot(Y)) | (D & M).
    - If nxt ≠ 0: P ← nxt, Y ← enc(nxt), V stays 1 (back-to-back, no bubble).
    - Else: P ← 0, Y ← 0, V ← 0 (→ IDLE).
- Set beats clear: if D[Y] & M[Y] is high in the ack cycle, bit Y stays pending and can be presented again.
- ack while V = 0 is ignored, with no side effects.
- Every P bit is sticky until retired by ack. No request is ever lost or duplicated without a new assertion.

## Timing
- Reset (rst high at an edge): P = 8'h00, V = 0, Y = 3'd0 after that edge. Reset overrides everything, including ack and D in the same cycle. Reset mid-handshake discards all pending requests.
- Latency: D[i] high (with M[i]) before edge k while IDLE gives V = 1 and Y = i after edge k (1 cycle).
- Handshake: the transfer occurs at an edge where V = 1 and ack = 1. Y is stable for every cycle V = 1 until that edge.
- Back-to-back: with k pending requests and ack held high, each of the k codes is presented for exactly 1 cycle, in priority order.
- The lowest-priority request can starve under continuous higher-priority re-assertion. This is by design; no fairness is provided.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package `enc_pkg` holds:
  - REQ_W = 8 and CODE_W = 3.
  - The state encoding constants ST_IDLE = 1'b0 and ST_PRESENT = 1'b1.
  - HIGH_FIRST default.
- Sub-module `priority_encoder_8_3` is purely combinational: 8-bit in, 3-bit code plus any-bit flag out, HIGH_FIRST parameter. It is instantiated twice, once for enc(req) and once for enc(nxt).
- onehot(Y) uses the existing 3-to-8 decoder.

## Test plan
- Reset: drive D = 8'hFF, M = 8'hFF, rst = 1 for 2 cycles → P = 00, V = 0, Y = 0. After rst falls → V = 1, Y = 7 after 1 edge.
- Single request: idle, D = 8'h10 pulsed 1 cycle, M = FF → V = 1, Y = 4, P = 10. Hold ack = 0 for 5 cycles → Y = 4 stable. Pulse ack → V = 0, Y = 0, P = 00 next cycle.
- Back-to-back: D = 8'hA5 pulsed, ack held high, HIGH_FIRST = 1 → Y sequence 7, 5, 2, 0 on consecutive cycles, then V = 0. With HIGH_FIRST = 0 → sequence 0, 2, 5, 7.
- No preemption plus set-wins: presenting Y = 3. Assert D = 8'h80 (no ack) → Y stays 3. Then ack with D[3] = 1 → Y = 7 next, and P keeps bit 3 set so 3 is presented after 7.
- Mask: M = 8'h0F, D = 8'hF0 → V stays 0, P = 00. Set M = FF → V = 1, Y = 7. Clearing M while pending → P is unchanged.
- Reset mid-operation: P = 8'h3C, V = 1, rst asserted together with ack → P = 00, V = 0, Y = 0. Nothing is presented afterwards without new requests.
